// File: rtl/turn_aim_ctrl_if.sv
// Turn/aim controller bus: frame, key and alive inputs in; launch and aim state out.
interface turn_aim_ctrl_if #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned PW          = 3,
    parameter int unsigned ANGLE_W     = 4,
    parameter int unsigned POWER_W     = 3
);
    logic                           frame_tick;
    logic [7:0]                     keycode;
    logic                           exploded;
    logic [NUM_PLAYERS-1:0]         alive;
    logic                           launch;
    logic [PW-1:0]                  active_player;
    logic [ANGLE_W-1:0]             cur_angle;
    logic [POWER_W-1:0]             cur_power;
    logic [NUM_PLAYERS*ANGLE_W-1:0] angle_bus;
    logic [NUM_PLAYERS*POWER_W-1:0] power_bus;
    logic [1:0]                     phase;
    logic [9:0]                     turn_timer;
    logic                           game_over;

    modport master (
        output frame_tick, keycode, exploded, alive,
        input  launch, active_player, cur_angle, cur_power,
               angle_bus, power_bus, phase, turn_timer, game_over
    );

    modport slave (
        input  frame_tick, keycode, exploded, alive,
        output launch, active_player, cur_angle, cur_power,
               angle_bus, power_bus, phase, turn_timer, game_over
    );
endinterface

// File: rtl/turn_aim_ctrl.sv
// Multi-player turn sequencer: per-player angle/power, aim -> flight -> settle -> next.
module turn_aim_ctrl #(
    parameter int unsigned NUM_PLAYERS   = 4,
    parameter int unsigned PW            = 3,
    parameter int unsigned ANGLE_W       = 4,
    parameter int unsigned POWER_W       = 3,
    parameter int unsigned ANGLE_MAX     = 8,
    parameter int unsigned POWER_MAX     = 7,
    parameter int unsigned ANGLE_INIT    = 6,
    parameter int unsigned POWER_INIT    = 2,
    parameter int unsigned AIM_DIV       = 16,
    parameter int unsigned TURN_FRAMES   = 600,
    parameter int unsigned FLIGHT_FRAMES = 255,
    parameter int unsigned SETTLE_FRAMES = 60
) (
    input  logic           clk,
    input  logic           reset,
    turn_aim_ctrl_if.slave bus
);
    localparam int unsigned AIM_W = 8;
    localparam int unsigned TMR_W = 10;
    localparam int unsigned FLT_W = 8;
    localparam int unsigned STL_W = 8;
    localparam int unsigned CNT_W = $clog2(NUM_PLAYERS + 1);

    localparam logic [7:0] KEY_ANGLE_DN = 8'h14;
    localparam logic [7:0] KEY_ANGLE_UP = 8'h08;
    localparam logic [7:0] KEY_POWER_DN = 8'h1E;
    localparam logic [7:0] KEY_POWER_UP = 8'h20;
    localparam logic [7:0] KEY_LAUNCH   = 8'h16;

    typedef enum logic [1:0] {
        PH_AIM    = 2'b00,
        PH_FLIGHT = 2'b01,
        PH_SETTLE = 2'b10,
        PH_NEXT   = 2'b11
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [PW-1:0]      active_q, active_d;
    logic [ANGLE_W-1:0] angle_q [NUM_PLAYERS];
    logic [ANGLE_W-1:0] angle_d [NUM_PLAYERS];
    logic [POWER_W-1:0] power_q [NUM_PLAYERS];
    logic [POWER_W-1:0] power_d [NUM_PLAYERS];
    logic [AIM_W-1:0]   aim_cnt_q, aim_cnt_d;
    logic [TMR_W-1:0]   turn_timer_q, turn_timer_d;
    logic [FLT_W-1:0]   flight_cnt_q, flight_cnt_d;
    logic [STL_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               launch_q, launch_d;
    logic               game_over_q, game_over_d;
    logic [ANGLE_W-1:0] cur_angle_q, cur_angle_d;
    logic [POWER_W-1:0] cur_power_q, cur_power_d;

    logic [ANGLE_W-1:0] act_angle_c, angle_nxt_c;
    logic [POWER_W-1:0] act_power_c, power_nxt_c;
    logic [PW-1:0]      next_player_c;
    logic               found_c;
    logic [CNT_W-1:0]   alive_cnt_c;
    logic [NUM_PLAYERS*ANGLE_W-1:0] angle_bus_c;
    logic [NUM_PLAYERS*POWER_W-1:0] power_bus_c;

    // Current aim of the active player.
    always_comb begin
        act_angle_c = angle_q[0];
        act_power_c = power_q[0];
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active_q == PW'(i)) begin
                act_angle_c = angle_q[i];
                act_power_c = power_q[i];
            end
        end
    end

    // Alive count and the next alive player after the active one (wrapping).
    always_comb begin
        alive_cnt_c   = '0;
        next_player_c = active_q;
        found_c       = 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            alive_cnt_c = alive_cnt_c + CNT_W'(bus.alive[i]);
        end
        for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (!found_c && bus.alive[i] && ((32'(active_q) + k) % NUM_PLAYERS) == i) begin
                    found_c       = 1'b1;
                    next_player_c = PW'(i);
                end
            end
        end
    end

    // Phase sequencing, key handling and counters.
    always_comb begin
        phase_d      = phase_q;
        active_d     = active_q;
        angle_d      = angle_q;
        power_d      = power_q;
        aim_cnt_d    = aim_cnt_q;
        turn_timer_d = turn_timer_q;
        flight_cnt_d = flight_cnt_q;
        settle_cnt_d = settle_cnt_q;
        launch_d     = 1'b0;
        angle_nxt_c  = act_angle_c;
        power_nxt_c  = act_power_c;
        game_over_d  = game_over_q | (alive_cnt_c <= CNT_W'(1));

        if (game_over_q) begin
            phase_d = PH_AIM;
        end else begin
            case (phase_q)
                PH_AIM: begin
                    if (bus.frame_tick) begin
                        aim_cnt_d = (aim_cnt_q == '1) ? aim_cnt_q : aim_cnt_q + AIM_W'(1);
                        if (turn_timer_q != '0) begin
                            turn_timer_d = turn_timer_q - TMR_W'(1);
                        end
                        if (aim_cnt_q >= AIM_W'(AIM_DIV)) begin
                            case (bus.keycode)
                                KEY_ANGLE_DN: if (act_angle_c != '0) begin
                                    angle_nxt_c = act_angle_c - ANGLE_W'(1);
                                    aim_cnt_d   = '0;
                                end
                                KEY_ANGLE_UP: if (act_angle_c < ANGLE_W'(ANGLE_MAX)) begin
                                    angle_nxt_c = act_angle_c + ANGLE_W'(1);
                                    aim_cnt_d   = '0;
                                end
                                KEY_POWER_DN: if (act_power_c != '0) begin
                                    power_nxt_c = act_power_c - POWER_W'(1);
                                    aim_cnt_d   = '0;
                                end
                                KEY_POWER_UP: if (act_power_c < POWER_W'(POWER_MAX)) begin
                                    power_nxt_c = act_power_c + POWER_W'(1);
                                    aim_cnt_d   = '0;
                                end
                                KEY_LAUNCH: begin
                                    launch_d     = 1'b1;
                                    aim_cnt_d    = '0;
                                    flight_cnt_d = '0;
                                    phase_d      = PH_FLIGHT;
                                end
                                default: ;
                            endcase
                        end
                        // Launch on the final tick beats the timeout.
                        if (!launch_d && turn_timer_q == TMR_W'(1)) begin
                            phase_d = PH_NEXT;
                        end
                    end
                end
                PH_FLIGHT: begin
                    if (bus.exploded) begin
                        phase_d      = PH_SETTLE;
                        settle_cnt_d = STL_W'(SETTLE_FRAMES);
                    end else if (bus.frame_tick) begin
                        flight_cnt_d = flight_cnt_q + FLT_W'(1);
                        if (flight_cnt_q >= FLT_W'(FLIGHT_FRAMES - 1)) begin
                            phase_d      = PH_SETTLE;
                            settle_cnt_d = STL_W'(SETTLE_FRAMES);
                        end
                    end
                end
                PH_SETTLE: begin
                    if (bus.frame_tick) begin
                        if (settle_cnt_q <= STL_W'(1)) begin
                            settle_cnt_d = '0;
                            phase_d      = PH_NEXT;
                        end else begin
                            settle_cnt_d = settle_cnt_q - STL_W'(1);
                        end
                    end
                end
                default: begin
                    active_d     = next_player_c;
                    phase_d      = PH_AIM;
                    aim_cnt_d    = '0;
                    turn_timer_d = TMR_W'(TURN_FRAMES);
                end
            endcase
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active_q == PW'(i)) begin
                angle_d[i] = angle_nxt_c;
                power_d[i] = power_nxt_c;
            end
        end
    end

    // Registered view of the aim belonging to the next active player.
    always_comb begin
        cur_angle_d = angle_d[0];
        cur_power_d = power_d[0];
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active_d == PW'(i)) begin
                cur_angle_d = angle_d[i];
                cur_power_d = power_d[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= PH_AIM;
            active_q     <= '0;
            aim_cnt_q    <= '0;
            turn_timer_q <= TMR_W'(TURN_FRAMES);
            flight_cnt_q <= '0;
            settle_cnt_q <= '0;
            launch_q     <= 1'b0;
            game_over_q  <= 1'b0;
            cur_angle_q  <= ANGLE_W'(ANGLE_INIT);
            cur_power_q  <= POWER_W'(POWER_INIT);
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                angle_q[i] <= ANGLE_W'(ANGLE_INIT);
                power_q[i] <= POWER_W'(POWER_INIT);
            end
        end else begin
            phase_q      <= phase_d;
            active_q     <= active_d;
            aim_cnt_q    <= aim_cnt_d;
            turn_timer_q <= turn_timer_d;
            flight_cnt_q <= flight_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            launch_q     <= launch_d;
            game_over_q  <= game_over_d;
            cur_angle_q  <= cur_angle_d;
            cur_power_q  <= cur_power_d;
            angle_q      <= angle_d;
            power_q      <= power_d;
        end
    end

    // Flatten per-player settings onto the packed buses.
    always_comb begin
        angle_bus_c = '0;
        power_bus_c = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            angle_bus_c[i*ANGLE_W +: ANGLE_W] = angle_q[i];
            power_bus_c[i*POWER_W +: POWER_W] = power_q[i];
        end
    end

    assign bus.launch        = launch_q;
    assign bus.active_player = active_q;
    assign bus.cur_angle     = cur_angle_q;
    assign bus.cur_power     = cur_power_q;
    assign bus.angle_bus     = angle_bus_c;
    assign bus.power_bus     = power_bus_c;
    assign bus.phase         = phase_q;
    assign bus.turn_timer    = turn_timer_q;
    assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_turn_aim_ctrl.sv
// Bench for turn_aim_ctrl: vector table, hand sequences, random run vs reference model.
module tb_turn_aim_ctrl;
    localparam int NP      = 4;
    localparam int AIM_DIV = 16;
    localparam int TURN    = 600;
    localparam int FLIGHT  = 255;
    localparam int SETTLE  = 60;
    localparam int ANG_MAX = 8;
    localparam int POW_MAX = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    turn_aim_ctrl_if #(.NUM_PLAYERS(4), .PW(3), .ANGLE_W(4), .POWER_W(3)) bus ();
    turn_aim_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit saw_launch;

    typedef struct {
        bit          tick;
        logic [7:0]  key;
        bit          expl;
        logic [3:0]  alive;
        int          n;
        logic [1:0]  ph;
        logic [2:0]  act;
        bit          lau;
        logic [15:0] ang;
        logic [9:0]  tmr;   // 10'h3FF = not checked
    } vec_t;
    vec_t vecs[$];

    // Reference model state: plain integers per player.
    int m_ph, m_act, m_aim, m_tmr, m_fl, m_st;
    int m_ang[NP];
    int m_pow[NP];
    bit m_lau, m_go;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic cyc(input bit tick, input logic [7:0] key, input bit expl);
        bus.frame_tick = tick;
        bus.keycode    = key;
        bus.exploded   = expl;
        @(posedge clk);
        #1;
        if (bus.launch) saw_launch = 1'b1;
        bus.frame_tick = 1'b0;
        bus.exploded   = 1'b0;
    endtask

    task automatic run(input int n, input bit tick, input logic [7:0] key, input bit expl);
        for (int i = 0; i < n; i++) cyc(tick, key, expl);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.keycode    = 8'h00;
        bus.exploded   = 1'b0;
        bus.alive      = 4'hF;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic m_reset();
        m_ph = 0; m_act = 0; m_aim = 0; m_tmr = TURN; m_fl = 0; m_st = 0;
        m_lau = 0; m_go = 0;
        for (int i = 0; i < NP; i++) begin
            m_ang[i] = 6;
            m_pow[i] = 2;
        end
    endtask

    // One clock of the turn rules, applied to the inputs seen at that edge.
    task automatic m_step(input bit tick, input logic [7:0] key, input bit ex, input logic [3:0] al);
        bit ready, acted, fired;
        int old_t;
        m_lau = 0;
        if (m_go) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            if (tick) begin
                ready = (m_aim >= AIM_DIV);
                acted = 0;
                fired = 0;
                old_t = m_tmr;
                m_aim = (m_aim < 255) ? m_aim + 1 : 255;
                if (m_tmr > 0) m_tmr = m_tmr - 1;
                if (ready) begin
                    case (key)
                        8'h14: if (m_ang[m_act] > 0)       begin m_ang[m_act]--; acted = 1; end
                        8'h08: if (m_ang[m_act] < ANG_MAX) begin m_ang[m_act]++; acted = 1; end
                        8'h1E: if (m_pow[m_act] > 0)       begin m_pow[m_act]--; acted = 1; end
                        8'h20: if (m_pow[m_act] < POW_MAX) begin m_pow[m_act]++; acted = 1; end
                        8'h16: fired = 1;
                        default: ;
                    endcase
                end
                if (acted || fired) m_aim = 0;
                if (fired) begin
                    m_lau = 1; m_ph = 1; m_fl = 0;
                end else if (old_t == 1) begin
                    m_ph = 3;
                end
            end
        end else if (m_ph == 1) begin
            if (ex) begin
                m_ph = 2; m_st = SETTLE;
            end else if (tick) begin
                m_fl++;
                if (m_fl >= FLIGHT) begin m_ph = 2; m_st = SETTLE; end
            end
        end else if (m_ph == 2) begin
            if (tick) begin
                m_st--;
                if (m_st <= 0) begin m_st = 0; m_ph = 3; end
            end
        end else begin
            for (int k = 1; k <= NP; k++) begin
                if (al[(m_act + k) % NP]) begin
                    m_act = (m_act + k) % NP;
                    break;
                end
            end
            m_ph = 0; m_aim = 0; m_tmr = TURN;
        end
        if ($countones(al) <= 1) m_go = 1;
    endtask

    function automatic logic [51:0] m_pack();
        logic [15:0] ab;
        logic [11:0] pb;
        ab = '0;
        pb = '0;
        for (int i = 0; i < NP; i++) begin
            ab[i*4 +: 4] = 4'(m_ang[i]);
            pb[i*3 +: 3] = 3'(m_pow[i]);
        end
        return {m_lau, 2'(m_ph), 3'(m_act), 10'(m_tmr), m_go, ab, pb,
                4'(m_ang[m_act]), 3'(m_pow[m_act])};
    endfunction

    function automatic logic [51:0] dut_pack();
        return {bus.launch, bus.phase, bus.active_player, bus.turn_timer, bus.game_over,
                bus.angle_bus, bus.power_bus, bus.cur_angle, bus.cur_power};
    endfunction

    initial begin
        logic [7:0] keys  [8] = '{8'h14, 8'h08, 8'h1E, 8'h20, 8'h16, 8'h00, 8'h33, 8'h16};
        logic [3:0] masks [6] = '{4'hF, 4'hB, 4'h5, 4'h3, 4'hE, 4'h9};
        logic [3:0] al;
        logic [7:0] key;
        bit tick, ex, quiet;
        int f0;

        // Turn sequence table: inputs held for n clocks, then expectations.
        vecs.push_back('{1, 8'h08, 0, 4'hF, 16,  2'd0, 3'd0, 0, 16'h6666, 10'd584});
        vecs.push_back('{1, 8'h08, 0, 4'hF, 1,   2'd0, 3'd0, 0, 16'h6667, 10'd583});
        vecs.push_back('{1, 8'h08, 0, 4'hF, 17,  2'd0, 3'd0, 0, 16'h6668, 10'd566});
        vecs.push_back('{1, 8'h08, 0, 4'hF, 166, 2'd0, 3'd0, 0, 16'h6668, 10'd400});
        vecs.push_back('{1, 8'h16, 0, 4'hF, 1,   2'd1, 3'd0, 1, 16'h6668, 10'd399});
        vecs.push_back('{0, 8'h00, 0, 4'hF, 1,   2'd1, 3'd0, 0, 16'h6668, 10'd399});
        vecs.push_back('{0, 8'h00, 1, 4'hF, 1,   2'd2, 3'd0, 0, 16'h6668, 10'd399});
        vecs.push_back('{1, 8'h00, 0, 4'hF, 59,  2'd2, 3'd0, 0, 16'h6668, 10'd399});
        vecs.push_back('{1, 8'h00, 0, 4'hF, 1,   2'd3, 3'd0, 0, 16'h6668, 10'd399});
        vecs.push_back('{0, 8'h00, 0, 4'hF, 1,   2'd0, 3'd1, 0, 16'h6668, 10'd600});
        for (int t = 0; t < 2; t++) begin
            logic [2:0] a_now, a_next;
            a_now  = (t == 0) ? 3'd1 : 3'd3;
            a_next = (t == 0) ? 3'd3 : 3'd0;
            vecs.push_back('{1, 8'h00, 0, 4'hB, 16, 2'd0, a_now,  0, 16'h6668, 10'd584});
            vecs.push_back('{1, 8'h16, 0, 4'hB, 1,  2'd1, a_now,  1, 16'h6668, 10'd583});
            vecs.push_back('{0, 8'h00, 1, 4'hB, 1,  2'd2, a_now,  0, 16'h6668, 10'd583});
            vecs.push_back('{1, 8'h00, 0, 4'hB, 60, 2'd3, a_now,  0, 16'h6668, 10'd583});
            vecs.push_back('{0, 8'h00, 0, 4'hB, 1,  2'd0, a_next, 0, 16'h6668, 10'd600});
        end
        vecs.push_back('{1, 8'h00, 0, 4'hF, 599, 2'd0, 3'd0, 0, 16'h6668, 10'd1});
        vecs.push_back('{1, 8'h00, 0, 4'hF, 1,   2'd3, 3'd0, 0, 16'h6668, 10'h3FF});
        vecs.push_back('{0, 8'h00, 0, 4'hF, 1,   2'd0, 3'd1, 0, 16'h6668, 10'd600});

        do_reset();
        chk("reset_state", 64'({bus.phase, bus.active_player, bus.launch, bus.game_over, bus.turn_timer,
                                bus.angle_bus, bus.power_bus, bus.cur_angle, bus.cur_power}),
            64'({2'd0, 3'd0, 1'b0, 1'b0, 10'd600, 16'h6666, 12'h492, 4'd6, 3'd2}));

        foreach (vecs[r]) begin
            saw_launch = 1'b0;
            bus.alive  = vecs[r].alive;
            run(vecs[r].n, vecs[r].tick, vecs[r].key, vecs[r].expl);
            chk($sformatf("vec%0d", r),
                64'({bus.phase, bus.active_player, saw_launch, bus.angle_bus}),
                64'({vecs[r].ph, vecs[r].act, vecs[r].lau, vecs[r].ang}));
            if (vecs[r].tmr != 10'h3FF)
                chk($sformatf("vec%0d_timer", r), 64'(bus.turn_timer), 64'(vecs[r].tmr));
        end

        // Lost bomb: flight times out into SETTLE after FLIGHT ticks.
        run(16, 1, 8'h00, 0);
        saw_launch = 1'b0;
        run(1, 1, 8'h16, 0);
        chk("flight_launch", 64'(saw_launch), 64'd1);
        run(254, 1, 8'h00, 0);
        chk("flight_254", 64'(bus.phase), 64'd1);
        run(1, 1, 8'h00, 0);
        chk("flight_timeout", 64'(bus.phase), 64'd2);
        run(60, 1, 8'h00, 0);
        run(1, 0, 8'h00, 0);
        chk("after_lost", 64'({bus.phase, bus.active_player}), 64'({2'd0, 3'd2}));
        run(17, 1, 8'h20, 0);
        chk("power_up_p2", 64'({bus.power_bus, bus.cur_power}), 64'({12'h4D2, 3'd3}));
        run(16, 1, 8'h00, 0);
        run(1, 1, 8'h16, 0);
        run(10, 1, 8'h00, 0);
        chk("mid_flight", 64'(bus.phase), 64'd1);

        // Asynchronous reset mid-flight, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("async_reset", 64'({bus.phase, bus.active_player, bus.launch, bus.angle_bus, bus.power_bus, bus.turn_timer}),
            64'({2'd0, 3'd0, 1'b0, 16'h6666, 12'h492, 10'd600}));
        @(posedge clk);
        #1 reset = 1'b0;

        // Game over: single survivor freezes the block in AIM.
        bus.alive = 4'b0100;
        chk("go_before", 64'(bus.game_over), 64'd0);
        run(1, 0, 8'h00, 0);
        chk("go_after", 64'(bus.game_over), 64'd1);
        saw_launch = 1'b0;
        run(40, 1, 8'h16, 0);
        run(40, 1, 8'h08, 0);
        chk("go_frozen", 64'({saw_launch, bus.phase, bus.angle_bus, bus.game_over}),
            64'({1'b0, 2'd0, 16'h6666, 1'b1}));

        // Random run against the reference model.
        do_reset();
        m_reset();
        al = 4'hF;
        quiet = 1'b0;
        f0 = failures;
        for (int c = 0; c < 20000 && (failures - f0) < 10; c++) begin
            if (c % 1500 == 0) quiet = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) al = masks[$urandom_range(0, 5)];
            tick = ($urandom_range(0, 3) != 0);
            key  = keys[$urandom_range(0, 7)];
            if (quiet && key == 8'h16) key = 8'h00;
            ex   = ($urandom_range(0, 40) == 0);
            bus.alive = al;
            cyc(tick, key, ex);
            m_step(tick, key, ex, al);
            chk($sformatf("random_cyc%0d", c), 64'(dut_pack()), 64'(m_pack()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
